mem_access_sequencer: RTL and testbench

MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

---
 rtl/mem_access_sequencer.sv | 158 +++++++++++++++
 tb/tb_mem_access_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer.sv
// Burst memory access sequencer: drives MAR/MBR strobes beat by beat,
// waits on MFC with a timeout, and reports Done or Error.
module mem_access_sequencer #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [3:0]        Beats,
  input  logic [DATA_W-1:0] WData,
  input  logic              MFC,
  input  logic [DATA_W-1:0] MemDataIn,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDataOut,
  output logic              MARLOAD,
  output logic              MBRLOAD,
  output logic              MBRSTORE,
  output logic              MFA,
  output logic              READ_WRITE,
  output logic [1:0]        SizeOut,
  output logic [DATA_W-1:0] RData,
  output logic              RValid,
  output logic              WReady,
  output logic              Busy,
  output logic              Done,
  output logic              Error
);

  typedef enum logic [2:0] {
    IDLE, SETUP, REQ, CAPTURE, NEXT, DONE, ERR
  } state_t;

  state_t              state, state_n;
  logic                rw_q;
  logic [3:0]          beats_q;
  logic [7:0]          wait_q;
  logic                legal;
  logic                rw_eff;
  logic                to_hit;
  logic [ADDR_W-1:0]   step;
  logic [DATA_W-1:0]   rd_ext;

  always_comb begin
    legal = 1'b1;
    if (Size == 2'b11)
      legal = 1'b0;
    if (Beats == 4'd0 || Beats > 4'(MAX_BEATS))
      legal = 1'b0;
    if (Size == 2'b10 && DATA_W == 16)
      legal = 1'b0;
    if (Size == 2'b01 && Addr[0])
      legal = 1'b0;
    if (Size == 2'b10 && Addr[1:0] != 2'b00)
      legal = 1'b0;
  end

  assign to_hit = (wait_q == 8'(TIMEOUT - 1));
  assign rw_eff = (state == IDLE) ? RW : rw_q;
  assign step   = ADDR_W'(3'd1 << SizeOut);
  assign Busy   = (state != IDLE);

  always_comb begin
    rd_ext = MemDataIn;
    unique case (1'b1)
      (SizeOut == 2'b00): rd_ext = DATA_W'(MemDataIn[7:0]);
      (SizeOut == 2'b01): rd_ext = DATA_W'(MemDataIn[15:0]);
      default: ;
    endcase
  end

  // MFC wins over the timeout when both land in the same cycle
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (Start) state_n = legal ? SETUP : ERR;
      SETUP:   state_n = REQ;
      REQ: begin
        if (MFC)
          state_n = rw_q ? CAPTURE : NEXT;
        else if (to_hit)
          state_n = ERR;
      end
      CAPTURE: state_n = NEXT;
      NEXT:    state_n = (beats_q == 4'd1) ? DONE : SETUP;
      DONE:    state_n = IDLE;
      ERR:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // strobes decode the next state so they line up with the state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      rw_q       <= 1'b0;
      beats_q    <= '0;
      wait_q     <= '0;
      SizeOut    <= '0;
      MemAddr    <= '0;
      MemDataOut <= '0;
      RData      <= '0;
      MARLOAD    <= 1'b0;
      MBRLOAD    <= 1'b0;
      MBRSTORE   <= 1'b0;
      MFA        <= 1'b0;
      READ_WRITE <= 1'b0;
      RValid     <= 1'b0;
      WReady     <= 1'b0;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      state      <= state_n;
      MARLOAD    <= (state_n == SETUP);
      WReady     <= (state_n == SETUP) && !rw_eff;
      MBRLOAD    <= ((state_n == SETUP) && !rw_eff) ||
                    (state_n == CAPTURE);
      MFA        <= (state_n == REQ);
      MBRSTORE   <= (state_n == REQ) && !rw_eff;
      READ_WRITE <= (state_n == REQ) && rw_eff;
      RValid     <= (state_n == CAPTURE);
      Done       <= (state_n == DONE);
      Error      <= (state_n == ERR);

      if (state == REQ)
        wait_q <= wait_q + 8'd1;
      else
        wait_q <= '0;

      if (state == IDLE && Start) begin
        rw_q    <= RW;
        SizeOut <= Size;
        MemAddr <= Addr;
        beats_q <= Beats;
      end

      if (state == NEXT) begin
        beats_q <= beats_q - 4'd1;
        if (state_n == SETUP)
          MemAddr <= MemAddr + step;
      end

      if (state == SETUP && !rw_q)
        MemDataOut <= WData;

      if (state == REQ && MFC && rw_q) begin
        MemDataOut <= MemDataIn;
        RData      <= rd_ext;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed table, reset and idle-MFC
// sequences, then randomized bursts against a transaction-level model.
module tb_mem_access_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 4;
  localparam int TO = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          Start;
  logic          RW;
  logic [1:0]    Size;
  logic [AW-1:0] Addr;
  logic [3:0]    Beats;
  logic [DW-1:0] WData;
  logic          MFC;
  logic [DW-1:0] MemDataIn;
  logic [AW-1:0] MemAddr;
  logic [DW-1:0] MemDataOut;
  logic          MARLOAD, MBRLOAD, MBRSTORE, MFA, READ_WRITE;
  logic [1:0]    SizeOut;
  logic [DW-1:0] RData;
  logic          RValid, WReady, Busy, Done, Error;

  mem_access_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_BEATS(MB), .TIMEOUT(TO)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .RW(RW),
    .Size(Size), .Addr(Addr), .Beats(Beats), .WData(WData),
    .MFC(MFC), .MemDataIn(MemDataIn), .MemAddr(MemAddr),
    .MemDataOut(MemDataOut), .MARLOAD(MARLOAD),
    .MBRLOAD(MBRLOAD), .MBRSTORE(MBRSTORE), .MFA(MFA),
    .READ_WRITE(READ_WRITE), .SizeOut(SizeOut), .RData(RData),
    .RValid(RValid), .WReady(WReady), .Busy(Busy),
    .Done(Done), .Error(Error)
  );

  always #5 Clk = ~Clk;

  int n_chk  = 0;
  int n_fail = 0;
  int dly[16];
  bit noise = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit legal_f(input logic [1:0] sz,
                                 input logic [31:0] ad,
                                 input logic [3:0] bt);
    if (sz == 2'b11) return 1'b0;
    if (bt == 0 || bt > MB) return 1'b0;
    if (sz == 2'b10 && DW == 16) return 1'b0;
    if (sz == 2'b01 && ad[0]) return 1'b0;
    if (sz == 2'b10 && ad[1:0] != 2'b00) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] zext(input logic [1:0] sz,
                                       input logic [31:0] d);
    case (sz)
      2'b00:   return d & 32'h0000_00FF;
      2'b01:   return d & 32'h0000_FFFF;
      default: return d;
    endcase
  endfunction

  task automatic run_txn(input bit rw, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [3:0] bt,
                         input int rst_beat, output bit got_err,
                         output logic [31:0] last_addr);
    bit          lg, exp_err, fin, prev_mfa;
    int          n_beats, exp_mfa, exp_rv, exp_wr;
    int          cyc, beat, mcnt, n_mar, n_mfa, n_rv, n_wr;
    int          n_done, n_err, err_lat;
    logic [31:0] wd;
    logic [31:0] rq[$];
    lg = legal_f(sz, ad, bt);
    exp_err = !lg;
    n_beats = lg ? int'(bt) : 0;
    for (int i = 0; i < n_beats; i++)
      if (dly[i] >= TO) begin
        n_beats = i + 1;
        exp_err = 1'b1;
        break;
      end
    exp_mfa = 0;
    for (int i = 0; i < n_beats; i++)
      exp_mfa += (dly[i] + 1 < TO) ? dly[i] + 1 : TO;
    exp_rv = 0;
    if (rw && lg) exp_rv = exp_err ? n_beats - 1 : n_beats;
    exp_wr = rw ? 0 : n_beats;
    fin = 0; prev_mfa = 0; cyc = 0; beat = -1; mcnt = 0;
    n_mar = 0; n_mfa = 0; n_rv = 0; n_wr = 0; n_done = 0;
    n_err = 0; err_lat = -1; wd = '0; last_addr = '0;
    got_err = 0;

    @(negedge Clk);
    Start = 1'b1; RW = rw; Size = sz; Addr = ad; Beats = bt;
    MFC = 1'b0;
    while (!fin && cyc < 400) begin
      @(negedge Clk);
      cyc++;
      if (MARLOAD) begin
        n_mar++;
        chk("mar_addr", MemAddr, ad + 32'((n_mar - 1) << sz));
      end
      if (MFA) begin
        if (!prev_mfa) begin
          beat++;
          mcnt = 0;
          last_addr = MemAddr;
          chk("mfa_addr", MemAddr, ad + 32'(beat << sz));
          chk("read_write", READ_WRITE, rw);
          chk("mbrstore", MBRSTORE, !rw);
          if (!rw) chk("mem_wdata", MemDataOut, wd);
        end
        mcnt++;
        n_mfa++;
        if (beat == rst_beat) begin
          #2 Reset = 1'b1;
          #1;
          chk("rst_mfa", MFA, 0);
          chk("rst_busy", Busy, 0);
          chk("rst_addr", MemAddr, 0);
          chk("rst_rdata", RData, 0);
          chk("rst_mbr", MemDataOut, 0);
          chk("rst_strobes",
              {MARLOAD, MBRLOAD, MBRSTORE, READ_WRITE, SizeOut}, 0);
          Start = 1'b0;
          MFC = 1'b0;
          @(negedge Clk);
          Reset = 1'b0;
          return;
        end
      end
      prev_mfa = MFA;
      if (RValid) begin
        n_rv++;
        if (rq.size() > 0) chk("rdata", RData, rq.pop_front());
      end
      if (WReady) n_wr++;
      if (Done) n_done++;
      if (Error) begin
        n_err++;
        if (err_lat < 0) err_lat = cyc;
        chk("err_sizeout", SizeOut, sz);
        chk("err_strobes", {MFA, MARLOAD, MBRSTORE, MBRLOAD}, 0);
      end
      if (Done || Error) fin = 1;
      Start = noise && Busy && ($urandom_range(2) == 0);
      WData = $urandom;
      if (WReady) wd = WData;
      MemDataIn = $urandom;
      if (MFA && (mcnt - 1) == dly[beat]) begin
        MFC = 1'b1;
        rq.push_back(zext(sz, MemDataIn));
      end else begin
        MFC = noise && !MFA && ($urandom_range(1) == 1);
      end
    end
    chk("txn_finished", fin, 1);
    chk("marload_cnt", n_mar, n_beats);
    chk("mfa_cycles", n_mfa, exp_mfa);
    chk("rvalid_cnt", n_rv, exp_rv);
    chk("wready_cnt", n_wr, exp_wr);
    chk("done_cnt", n_done, !exp_err);
    chk("error_cnt", n_err, exp_err);
    if (!lg) chk("err_latency", err_lat >= 1 && err_lat <= 2, 1);
    got_err = (n_err > 0);
    @(negedge Clk);
    Start = 1'b0;
    MFC = 1'b0;
    chk("busy_after", Busy, 0);
    chk("pulse_end", {Done, Error}, 0);
    @(negedge Clk);
    chk("busy_no_queue", Busy, 0);
  endtask

  typedef struct {
    string       name;
    bit          rw;
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [3:0]  bt;
    int          d;
    int          to_beat;
    bit          exp_err;
    logic [31:0] exp_last;
  } vec_t;

  vec_t vt[12];

  initial begin
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit          ge;
    logic [31:0] la;
    bit          rw;
    logic [1:0]  sz;
    logic [31:0] ad;
    logic [3:0]  bt;

    vt[0]  = '{"rd_word_x3",   1, 2'd2, 32'h100, 4'd3, 2, -1, 0, 32'h108};
    vt[1]  = '{"wr_byte_x2",   0, 2'd0, 32'h3,   4'd2, 1, -1, 0, 32'h4};
    vt[2]  = '{"bad_half",     1, 2'd1, 32'h101, 4'd1, 0, -1, 1, 32'h0};
    vt[3]  = '{"bad_size11",   1, 2'd3, 32'h100, 4'd1, 0, -1, 1, 32'h0};
    vt[4]  = '{"bad_beats5",   0, 2'd2, 32'h100, 4'd5, 0, -1, 1, 32'h0};
    vt[5]  = '{"bad_beats0",   1, 2'd0, 32'h10,  4'd0, 0, -1, 1, 32'h0};
    vt[6]  = '{"wrap_word",    1, 2'd2, 32'hFFFF_FFFC, 4'd2, 0, -1, 0,
               32'h0};
    vt[7]  = '{"timeout_rd",   1, 2'd2, 32'h40,  4'd1, 0, 0, 1, 32'h40};
    vt[8]  = '{"mfc_at_limit", 0, 2'd1, 32'h22,  4'd2, TO - 1, -1, 0,
               32'h24};
    vt[9]  = '{"rd_half_x4",   1, 2'd1, 32'h2,   4'd4, 0, -1, 0, 32'h8};
    vt[10] = '{"bad_word",     0, 2'd2, 32'h102, 4'd1, 0, -1, 1, 32'h0};
    vt[11] = '{"timeout_wr_b2", 0, 2'd2, 32'h10, 4'd3, 1, 1, 1, 32'h14};

    Reset = 1'b1; Start = 1'b0; RW = 1'b0; Size = '0; Addr = '0;
    Beats = '0; WData = '0; MFC = 1'b0; MemDataIn = '0;
    @(negedge Clk);
    chk("reset_busy", Busy, 0);
    chk("reset_addr", MemAddr, 0);
    chk("reset_mbr", MemDataOut, 0);
    chk("reset_rdata", RData, 0);
    chk("reset_strobes",
        {MARLOAD, MBRLOAD, MBRSTORE, MFA, READ_WRITE, RValid,
         WReady, Done, Error, SizeOut}, 0);
    Reset = 1'b0;
    @(negedge Clk);

    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < 16; j++) dly[j] = vt[i].d;
      if (vt[i].to_beat >= 0) dly[vt[i].to_beat] = TO + 3;
      run_txn(vt[i].rw, vt[i].sz, vt[i].ad, vt[i].bt, -1, ge, la);
      chk({vt[i].name, "_err"}, ge, vt[i].exp_err);
      if (!vt[i].exp_err || vt[i].to_beat >= 0)
        chk({vt[i].name, "_last"}, la, vt[i].exp_last);
      if (i == 7) begin
        for (int k = 0; k < 3; k++) begin
          MFC = 1'b1;
          MemDataIn = $urandom;
          @(negedge Clk);
          chk("idle_mfc_ignored",
              {Busy, MFA, RValid, Done, Error}, 0);
        end
        MFC = 1'b0;
      end
    end

    for (int j = 0; j < 16; j++) dly[j] = 1;
    run_txn(1, 2'd2, 32'h200, 4'd3, 1, ge, la);
    run_txn(1, 2'd2, 32'h300, 4'd3, -1, ge, la);
    chk("post_reset_burst_err", ge, 0);
    chk("post_reset_last", la, 32'h308);

    noise = 1'b1;
    for (int n = 0; n < 40; n++) begin
      rw = 1'($urandom_range(1));
      sz = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
      ad = $urandom;
      if ($urandom_range(3) != 0 && sz != 2'd3)
        ad = ad & ~((32'd1 << sz) - 32'd1);
      if ($urandom_range(5) == 0)
        ad = 32'hFFFF_FFF0 | (ad & 32'hF);
      bt = 4'($urandom_range(6));
      for (int j = 0; j < 16; j++) begin
        dly[j] = $urandom_range(4);
        if ($urandom_range(11) == 0) dly[j] = TO - 1;
        if ($urandom_range(13) == 0) dly[j] = TO + $urandom_range(3);
      end
      run_txn(rw, sz, ad, bt, -1, ge, la);
    end
    noise = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
